// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline control for the five-stage MIPS core. Arbitrates stall and flush
//   requests from ID, EX and the exception path, drives the per-stage stall
//   vector (bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb) and
//   sequences multi-cycle EX operations (DIV/DIVU).
//
//   Optional feature: define PIPE_CTRL_STALL_CNT_EN to build a 32-bit
//   stall-cycle counter on stall_cycles_o. Without it the port is tied to 0
//   and no counter flops exist.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned MC_CYCLES  = 32,            // legal range 2..63
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_TYPE  = 32'h0000_000e
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stallreq_i,
  input  logic        ex_mc_start_i,
  input  logic        excp_i,
  input  logic [31:0] excp_type_i,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        mc_ready_o,
  output logic        mc_busy_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The start cycle counts as the first stalled cycle and BUSY runs while the
  // counter goes from this value down to 0, giving MC_CYCLES stalled cycles.
  localparam logic [5:0] CNT_LOAD = 6'(MC_CYCLES - 2);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_MC   = 6'b001111;  // hold pc, if, id, ex
  localparam logic [5:0] STALL_ID   = 6'b000111;  // hold pc, if, id

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  // State register for the multi-cycle sequencer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: exceptions abandon any in-flight op; DONE always
  // returns to IDLE because ex_mc_start_i still reflects the completing op.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned, which
    // would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (excp_i) begin
      state_d = ST_IDLE;
      cnt_d   = 6'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ex_mc_start_i) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_BUSY: begin
          if (cnt_q == 6'd0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  // Output logic: flush beats the sequencer stall, which beats the ID
  // load-use stall. Held quiet while rst is asserted.
  always_comb begin
    stall_o    = STALL_NONE;
    flush_o    = 1'b0;
    new_pc_o   = 32'h0;
    mc_ready_o = 1'b0;
    if (!rst) begin
      if (excp_i) begin
        flush_o  = 1'b1;
        new_pc_o = (excp_type_i == ERET_TYPE) ? epc_i : EXC_VECTOR;
      end else if ((state_q == ST_IDLE && ex_mc_start_i) || state_q == ST_BUSY) begin
        stall_o = STALL_MC;
      end else if (state_q == ST_DONE) begin
        // Release everything so the EX result moves into ex_mem this cycle;
        // a pending ID request is picked up again on the following cycle.
        mc_ready_o = 1'b1;
      end else if (id_stallreq_i) begin
        stall_o = STALL_ID;
      end
    end
  end

  assign mc_busy_o = (state_q == ST_BUSY) || (state_q == ST_DONE);

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count cycles in which some stage is held and nothing is being flushed.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o != STALL_NONE && !flush_o) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall-cycle counter register, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Self-checking bench for pipe_ctrl. A behavioural model tracks how many
//   cycles have elapsed since a multi-cycle op was accepted and derives the
//   expected outputs from the pipeline rules directly.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int unsigned MC    = 32;
  localparam logic [31:0] VEC   = 32'h0000_0020;
  localparam logic [31:0] ERET  = 32'h0000_000e;
`ifdef PIPE_CTRL_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ready;
    logic        busy;
    logic [31:0] cnt;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_stallreq_i = 1'b0;
  logic        ex_mc_start_i = 1'b0;
  logic        excp_i = 1'b0;
  logic [31:0] excp_type_i = 32'h0;
  logic [31:0] epc_i = 32'h0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        mc_ready_o;
  logic        mc_busy_o;
  logic [31:0] stall_cycles_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: is an op in EX past its start cycle, and how many
  // cycles ago was it accepted.
  bit          m_active = 1'b0;
  int          m_since  = 0;
  logic [31:0] m_cnt    = 32'h0;

  pipe_ctrl #(
    .MC_CYCLES (MC),
    .EXC_VECTOR(VEC),
    .ERET_TYPE (ERET)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_stallreq_i (id_stallreq_i),
    .ex_mc_start_i (ex_mc_start_i),
    .excp_i        (excp_i),
    .excp_type_i   (excp_type_i),
    .epc_i         (epc_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .new_pc_o      (new_pc_o),
    .mc_ready_o    (mc_ready_o),
    .mc_busy_o     (mc_busy_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk = ~clk;

  function automatic outs_t model_expect(input logic r, id, st, ex,
                                         input logic [31:0] typ, epc);
    outs_t e;
    e       = '0;
    e.busy  = m_active;
    e.cnt   = CNT_EN ? m_cnt : 32'h0;
    if (r) return e;
    if (ex) begin
      e.flush  = 1'b1;
      e.new_pc = (typ == ERET) ? epc : VEC;
    end else if (m_active) begin
      if (m_since < int'(MC)) e.stall = 6'b001111;
      else                    e.ready = 1'b1;
    end else if (st) begin
      e.stall = 6'b001111;
    end else if (id) begin
      e.stall = 6'b000111;
    end
    return e;
  endfunction

  task automatic model_advance(input logic r, st, ex, input outs_t e);
    if (r)                               m_cnt = 32'h0;
    else if (e.stall != 6'd0 && !e.flush) m_cnt = m_cnt + 32'd1;
    if (r || ex) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_since == int'(MC)) m_active = 1'b0;
      else                     m_since  = m_since + 1;
    end else if (st) begin
      m_active = 1'b1;
      m_since  = 1;
    end
  endtask

  // Drive one cycle of inputs, sample the DUT mid-low-phase and produce the
  // model's expectation; the model then steps past the coming rising edge.
  task automatic drive_cycle(input logic r, id, st, ex,
                             input logic [31:0] typ, epc,
                             output outs_t obs, output outs_t exp);
    @(negedge clk);
    rst = r; id_stallreq_i = id; ex_mc_start_i = st; excp_i = ex;
    excp_type_i = typ; epc_i = epc;
    #2;
    obs = '{stall: stall_o, flush: flush_o, new_pc: new_pc_o,
            ready: mc_ready_o, busy: mc_busy_o, cnt: stall_cycles_o};
    exp = model_expect(r, id, st, ex, typ, epc);
    model_advance(r, st, ex, exp);
  endtask

  task automatic quiet_reset();
    outs_t o, e;
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, o, e);
  endtask

  task automatic test_reset();
    outs_t o, e;
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hffff_ffff, 32'hffff_ffff, o, e);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hffff_ffff, 32'hffff_ffff, o, e);
    tests_run++;
    if (o !== outs_t'('0)) begin
      tests_failed++;
      $display("FAIL reset_held: got %h want 0", o);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, o, e);
    tests_run++;
    if (o !== outs_t'('0)) begin
      tests_failed++;
      $display("FAIL reset_release: got %h want 0", o);
    end
  endtask

  task automatic test_load_use();
    outs_t o, e;
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, o, e);
    tests_run++;
    if (o.stall !== 6'b000111 || o !== e) begin
      tests_failed++;
      $display("FAIL load_use_stall: got %h want %h", o, e);
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, o, e);
    tests_run++;
    if (o.stall !== 6'b000000 || o !== e) begin
      tests_failed++;
      $display("FAIL load_use_release: got %h want %h", o, e);
    end
  endtask

  task automatic test_divide();
    outs_t o, e;
    int ready_at = -1;
    int busy_cnt = 0;
    for (int k = 0; k <= int'(MC); k++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, o, e);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL divide_cyc%0d: got %h want %h", k, o, e);
      end
      if (o.ready === 1'b1 && ready_at < 0) ready_at = k;
      if (o.busy === 1'b1) busy_cnt++;
    end
    tests_run++;
    if (ready_at != int'(MC) || busy_cnt != int'(MC)) begin
      tests_failed++;
      $display("FAIL divide_latency: ready_at %0d busy %0d want %0d/%0d",
               ready_at, busy_cnt, MC, MC);
    end
  endtask

  task automatic test_exception_mid_div();
    outs_t o, e;
    bit seen_ready = 1'b0;
    for (int k = 0; k < 10; k++)
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, o, e);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h1, 32'h1234_5678, o, e);
    tests_run++;
    if (o.flush !== 1'b1 || o.new_pc !== VEC || o.stall !== 6'd0 || o !== e) begin
      tests_failed++;
      $display("FAIL excp_mid_div: got %h want %h", o, e);
    end
    for (int k = 0; k < int'(MC) + 4; k++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, o, e);
      if (o.ready !== 1'b0) seen_ready = 1'b1;
      if (k == 0) begin
        tests_run++;
        if (o.busy !== 1'b0 || o !== e) begin
          tests_failed++;
          $display("FAIL excp_idle_after: got %h want %h", o, e);
        end
      end
    end
    tests_run++;
    if (seen_ready) begin
      tests_failed++;
      $display("FAIL excp_no_ready: got ready=1 want never");
    end
  endtask

  task automatic test_eret();
    outs_t o, e;
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, ERET, 32'hbfc0_0100, o, e);
    tests_run++;
    if (o.flush !== 1'b1 || o.new_pc !== 32'hbfc0_0100 || o !== e) begin
      tests_failed++;
      $display("FAIL eret: got %h want %h", o, e);
    end
  endtask

  task automatic test_counter();
    outs_t o, e;
    logic [31:0] want;
    quiet_reset();
    for (int k = 0; k < 3; k++)
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, o, e);
    for (int k = 0; k <= int'(MC); k++)
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, o, e);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, o, e);
    want = CNT_EN ? 32'd35 : 32'd0;
    tests_run++;
    if (o.cnt !== want || o !== e) begin
      tests_failed++;
      $display("FAIL stall_counter: got %0d want %0d", o.cnt, want);
    end
  endtask

  task automatic test_back_to_back();
    outs_t o, e;
    int errs = 0;
    // Start and ID request held for two complete ops plus one more start.
    for (int k = 0; k < 2 * (int'(MC) + 1) + 3; k++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, o, e);
      if (o !== e) begin
        errs++;
        if (errs < 4) $display("FAIL back_to_back_cyc%0d: got %h want %h", k, o, e);
      end
    end
    tests_run++;
    if (errs != 0) tests_failed++;
    // Reset in the middle of the third op returns straight to IDLE.
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, o, e);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, o, e);
    tests_run++;
    if (o.busy !== 1'b0 || o !== e) begin
      tests_failed++;
      $display("FAIL reset_mid_seq: got %h want %h", o, e);
    end
  endtask

  task automatic test_random();
    outs_t o, e;
    int errs = 0;
    logic r, id, st, ex;
    logic [31:0] typ, epc;
    for (int k = 0; k < 3000; k++) begin
      r   = ($urandom_range(0, 199) == 0);
      id  = ($urandom_range(0, 3) == 0);
      st  = ($urandom_range(0, 5) == 0) || (m_active && $urandom_range(0, 3) != 0);
      ex  = ($urandom_range(0, 39) == 0);
      typ = $urandom_range(0, 1) ? ERET : 32'($urandom_range(0, 31));
      epc = $urandom;
      drive_cycle(r, id, st, ex, typ, epc, o, e);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        errs++;
        if (errs < 6) $display("FAIL random_cyc%0d: got %h want %h", k, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_divide();
    test_exception_mid_div();
    test_eret();
    test_counter();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
